// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory request/response bus
interface instruction_fetch_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   modport master (output req_valid, output req_addr, input req_ready, input rsp_valid, input rsp_data);
   modport slave (input req_valid, input req_addr, output req_ready, output rsp_valid, output rsp_data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32I IF stage, single-outstanding fetch with stall, redirect and wrong-path kill
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall_i,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   instruction_fetch_unit_if.master  imem,
   output logic                      if_valid,
   output logic [31:0]               if_pc,
   output logic [31:0]               if_instr,
   output logic                      misaligned_fault
);
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
   state_t      state, state_d;
   logic [31:0] pc, pc_d, hold_buf, hold_buf_d, if_pc_d, if_instr_d, dlv_data;
   logic        kill, kill_d, if_valid_d, fault_d, dlv;
   assign imem.req_valid = state == FETCH;
   assign imem.req_addr  = pc;
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      kill_d     = kill;
      hold_buf_d = hold_buf;
      if_valid_d = stall_i & if_valid;
      if_pc_d    = if_pc;
      if_instr_d = if_instr;
      fault_d    = 1'b0;
      dlv        = 1'b0;
      dlv_data   = imem.rsp_data;
      case (state)
         IDLE: state_d = FETCH;
         FETCH: if (imem.req_ready) begin
            state_d = WAIT;
            kill_d  = redirect_valid;
         end
         WAIT: if (imem.rsp_valid) begin
            kill_d = 1'b0;
            if (kill || redirect_valid) state_d = FETCH;
            else if (stall_i) begin
               state_d    = HOLD;
               hold_buf_d = imem.rsp_data;
            end else begin
               state_d = FETCH;
               dlv     = 1'b1;
            end
         end else if (redirect_valid) kill_d = 1'b1;
         HOLD: if (redirect_valid || !stall_i) begin
            state_d  = FETCH;
            dlv      = !redirect_valid;
            dlv_data = hold_buf;
         end
         default: state_d = IDLE;
      endcase
      if (dlv) begin
         if_valid_d = 1'b1;
         if_pc_d    = pc;
         if_instr_d = dlv_data;
         pc_d       = pc + 32'd4;
      end
      // redirect overrides stall and delivery; an in-flight old-pc response is marked for drop above
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         hold_buf_d = '0;
         fault_d    = |redirect_pc[1:0];
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         pc               <= RESET_PC;
         kill             <= 1'b0;
         hold_buf         <= '0;
         if_valid         <= 1'b0;
         if_pc            <= '0;
         if_instr         <= NOP_INSTR;
         misaligned_fault <= 1'b0;
      end else begin
         state            <= state_d;
         pc               <= pc_d;
         kill             <= kill_d;
         hold_buf         <= hold_buf_d;
         if_valid         <= if_valid_d;
         if_pc            <= if_pc_d;
         if_instr         <= if_instr_d;
         misaligned_fault <= fault_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for the IF stage
module tb_instruction_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid, misaligned_fault;
   logic [31:0] if_pc, if_instr;
   logic        mem_en = 1'b1;
   logic        force_rsp = 1'b0;
   logic        pend = 1'b0;
   logic        stall_edge = 1'b0;
   logic [31:0] pend_addr = '0;
   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   exp_t        e;
   instruction_fetch_unit_if imem();
   instruction_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem(imem), .if_valid(if_valid), .if_pc(if_pc),
      .if_instr(if_instr), .misaligned_fault(misaligned_fault));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [31:0] a);
      q.push_back('{a, a ^ KEY});
   endtask
   task automatic wait_req(input logic [31:0] a);
      int n = 0;
      @(negedge clk);
      while (!imem.req_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_valid", 32'(imem.req_valid), 32'd1);
      chk("req_addr", imem.req_addr, a);
   endtask
   // memory model: answers one cycle after the accepting edge
   always @(negedge clk) begin
      if (!mem_en) begin
         pend = 1'b0;
         imem.rsp_valid = force_rsp;
      end else if (pend) begin
         imem.rsp_valid = 1'b1;
         imem.rsp_data = pend_addr ^ KEY;
         pend = 1'b0;
      end else begin
         imem.rsp_valid = 1'b0;
         if (imem.req_valid && imem.req_ready) begin
            pend = 1'b1;
            pend_addr = imem.req_addr;
         end
      end
   end
   always @(posedge clk) stall_edge = stall_i;
   always @(negedge clk) if (rst && if_valid && !stall_edge) begin
      chk("delivery_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("if_pc", if_pc, e.pc);
         chk("if_instr", if_instr, e.instr);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      imem.req_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, NOP);
      chk("rst_fault", 32'(misaligned_fault), 32'd0);
      chk("rst_req_valid", 32'(imem.req_valid), 32'd0);
      chk("rst_req_addr", imem.req_addr, 32'h0);
      rst = 1'b1;
      for (logic [31:0] a = 32'h0; a <= 32'h10; a += 32'h4) begin
         wait_req(a);
         push(a);
      end
      @(negedge clk);
      stall_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_if_valid", 32'(if_valid), 32'd0);
         chk("stall_if_pc", if_pc, 32'hC);
         chk("stall_if_instr", if_instr, 32'hC ^ KEY);
         chk("stall_no_req", 32'(imem.req_valid), 32'd0);
      end
      stall_i = 1'b0;
      for (logic [31:0] a = 32'h14; a <= 32'h3C; a += 32'h4) begin
         wait_req(a);
         push(a);
      end
      wait_req(32'h40);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("redir_if_valid", 32'(if_valid), 32'd0);
      chk("redir_if_instr", if_instr, NOP);
      wait_req(32'h200);
      chk("drop_0x40", 32'(if_valid), 32'd0);
      push(32'h200);
      wait_req(32'h204);
      @(negedge clk);
      stall_i = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      @(negedge clk);
      stall_i = 1'b0;
      redirect_valid = 1'b0;
      chk("rsp_redir_if_valid", 32'(if_valid), 32'd0);
      chk("rsp_redir_if_instr", if_instr, NOP);
      chk("rsp_redir_req_valid", 32'(imem.req_valid), 32'd1);
      chk("rsp_redir_req_addr", imem.req_addr, 32'h300);
      chk("aligned_no_fault", 32'(misaligned_fault), 32'd0);
      push(32'h300);
      wait_req(32'h304);
      chk("pre_fault", 32'(misaligned_fault), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("fault_pulse", 32'(misaligned_fault), 32'd1);
      @(negedge clk);
      chk("fault_cleared", 32'(misaligned_fault), 32'd0);
      chk("misaligned_req_valid", 32'(imem.req_valid), 32'd1);
      chk("misaligned_req_addr", imem.req_addr, 32'h100);
      push(32'h100);
      wait_req(32'h104);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_req(32'hFFFF_FFFC);
      push(32'hFFFF_FFFC);
      wait_req(32'h0);
      push(32'h0);
      wait_req(32'h4);
      push(32'h4);
      wait_req(32'h8);
      stall_i = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_reset_if_valid", 32'(if_valid), 32'd1);
      chk("pre_reset_if_pc", if_pc, 32'h4);
      #1;
      rst = 1'b0;
      mem_en = 1'b0;
      force_rsp = 1'b1;
      #1;
      chk("async_if_valid", 32'(if_valid), 32'd0);
      chk("async_if_pc", if_pc, 32'h0);
      chk("async_if_instr", if_instr, NOP);
      chk("async_req_valid", 32'(imem.req_valid), 32'd0);
      chk("async_req_addr", imem.req_addr, 32'h0);
      chk("async_fault", 32'(misaligned_fault), 32'd0);
      stall_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      force_rsp = 1'b0;
      @(negedge clk);
      chk("post_reset_req_addr", imem.req_addr, 32'h0);
      repeat (4) begin
         chk("late_rsp_no_valid", 32'(if_valid), 32'd0);
         @(negedge clk);
      end
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
